// File: rtl/mm_pkg.sv
// Shared types and helpers for the parallel matrix multiplier.
package mm_pkg;

  localparam int unsigned WORD = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Tiles per side: ceil(n / m).
  function automatic int unsigned tiles(input int unsigned n, input int unsigned m);
    return (n + m - 1) / m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 9,
  parameter int unsigned PTR_W   = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  int unsigned idx;

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!valid_o && req_i[PTR_W'(idx)]) begin
        gnt_o[PTR_W'(idx)] = 1'b1;
        valid_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_writeback_arbiter.sv
// Shares the result-matrix write port between all tile multipliers:
// round-robin grant, local-to-global address translation, per-tile
// completion tracking and a run-level done flag.
module result_writeback_arbiter
  import mm_pkg::*;
#(
  parameter  int unsigned n       = 10,
  parameter  int unsigned m       = 4,
  localparam int unsigned T       = tiles(n, m),
  localparam int unsigned NUM_REQ = T * T,
  localparam int unsigned n_len   = $clog2(n),
  localparam int unsigned m_len   = $clog2(m)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_REQ-1:0]       req_stb,
  input  logic [NUM_REQ*m_len-1:0] req_li,
  input  logic [NUM_REQ*m_len-1:0] req_lj,
  input  logic [NUM_REQ*WORD-1:0]  req_data,
  input  logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     wr_en,
  output logic [n_len-1:0]         wr_i,
  output logic [n_len-1:0]         wr_j,
  output logic [WORD-1:0]          wr_data,
  output logic [15:0]              wr_count,
  output logic [15:0]              drop_count,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW    = n_len + 1;
  localparam int unsigned CW    = 16;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   done_mask_q, done_mask_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 wr_en_q, wr_en_d;
  logic [n_len-1:0]     wr_i_q, wr_i_d;
  logic [n_len-1:0]     wr_j_q, wr_j_d;
  logic [WORD-1:0]      wr_data_q, wr_data_d;
  logic [CW-1:0]        wr_count_q, wr_count_d;
  logic [CW-1:0]        drop_count_q, drop_count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 arb_en;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_valid;
  logic [PTR_W-1:0]     gnt_idx;
  logic [m_len-1:0]     sel_li, sel_lj;
  logic [WORD-1:0]      sel_data;
  logic [AW-1:0]        base_i, base_j;
  logic [AW-1:0]        gi, gj;
  logic                 in_range;

  // A requester still holding its strobe during its ack cycle is not eligible.
  always_comb begin
    arb_en   = (state_q == RUN) || (state_q == DRAIN);
    eligible = arb_en ? (req_stb & ~ack_q) : '0;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  // Mux the granted tile's payload and translate to global coordinates.
  always_comb begin
    gnt_idx  = '0;
    sel_li   = '0;
    sel_lj   = '0;
    sel_data = '0;
    base_i   = '0;
    base_j   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gnt_idx  = PTR_W'(k);
        sel_li   = req_li[k*m_len +: m_len];
        sel_lj   = req_lj[k*m_len +: m_len];
        sel_data = req_data[k*WORD +: WORD];
        base_i   = AW'((k / T) * m);
        base_j   = AW'((k % T) * m);
      end
    end
    gi       = base_i + AW'(sel_li);
    gj       = base_j + AW'(sel_lj);
    in_range = (gi < AW'(n)) && (gj < AW'(n));
  end

  // Next-state, pointer, counters and registered write-port outputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    done_mask_d  = done_mask_q;
    ack_d        = '0;
    wr_en_d      = 1'b0;
    wr_i_d       = wr_i_q;
    wr_j_d       = wr_j_q;
    wr_data_d    = wr_data_q;
    wr_count_d   = wr_count_q;
    drop_count_d = drop_count_q;
    done_d       = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          ptr_d        = '0;
          done_mask_d  = '0;
          wr_count_d   = '0;
          drop_count_d = '0;
          done_d       = 1'b0;
        end
      end
      RUN: begin
        done_mask_d = done_mask_q | req_done;
        if (&done_mask_d) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!gnt_valid) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt_valid) begin
      ack_d     = gnt;
      ptr_d     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      wr_i_d    = n_len'(gi);
      wr_j_d    = n_len'(gj);
      wr_data_d = sel_data;
      if (in_range) begin
        wr_en_d = 1'b1;
        if (wr_count_q != '1) begin
          wr_count_d = wr_count_q + CW'(1);
        end
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CW'(1);
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  // State and output registers; reset aborts any in-flight grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      done_mask_q  <= '0;
      ack_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_i_q       <= '0;
      wr_j_q       <= '0;
      wr_data_q    <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      done_mask_q  <= done_mask_d;
      ack_q        <= ack_d;
      wr_en_q      <= wr_en_d;
      wr_i_q       <= wr_i_d;
      wr_j_q       <= wr_j_d;
      wr_data_q    <= wr_data_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign req_ack    = ack_q;
  assign wr_en      = wr_en_q;
  assign wr_i       = wr_i_q;
  assign wr_j       = wr_j_q;
  assign wr_data    = wr_data_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Directed bench for result_writeback_arbiter with n=10, m=4 (3x3 tiles).
module tb_result_writeback_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [8:0]   req_stb;
  logic [17:0]  req_li;
  logic [17:0]  req_lj;
  logic [287:0] req_data;
  logic [8:0]   req_done;
  logic [8:0]   req_ack;
  logic         wr_en;
  logic [3:0]   wr_i;
  logic [3:0]   wr_j;
  logic [31:0]  wr_data;
  logic [15:0]  wr_count;
  logic [15:0]  drop_count;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_writeback_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_stb    (req_stb),
    .req_li     (req_li),
    .req_lj     (req_lj),
    .req_data   (req_data),
    .req_done   (req_done),
    .req_ack    (req_ack),
    .wr_en      (wr_en),
    .wr_i       (wr_i),
    .wr_j       (wr_j),
    .wr_data    (wr_data),
    .wr_count   (wr_count),
    .drop_count (drop_count),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [1:0] li, input logic [1:0] lj,
                         input logic [31:0] d);
    req_stb[k]          = 1'b1;
    req_li[k*2 +: 2]    = li;
    req_lj[k*2 +: 2]    = lj;
    req_data[k*32 +: 32] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; req_stb = '0; req_done = '0;
    req_li = '0; req_lj = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({wr_en, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {wr_en, busy, done}); end
    checks++; if (req_ack !== 9'd0) begin errors++; $display("FAIL reset_ack: got %b expected 0", req_ack); end
    checks++; if ({wr_count, drop_count} !== 32'd0) begin errors++; $display("FAIL reset_counts: got %h expected 0", {wr_count, drop_count}); end
    rst = 1'b0;
    tick();
    set_req(4, 2'd1, 2'd2, 32'hDEAD_BEEF);
    repeat (3) tick();
    checks++; if ({req_ack, wr_en} !== 10'd0) begin errors++; $display("FAIL idle_ignore: got %b expected 0", {req_ack, wr_en}); end
    req_stb = '0;
  endtask

  task automatic test_single_write;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL start_busy: got %b expected 10", {busy, done}); end
    set_req(4, 2'd1, 2'd2, 32'hDEAD_BEEF);
    tick();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
    checks++; if ({wr_i, wr_j} !== {4'd5, 4'd6}) begin errors++; $display("FAIL single_addr: got i=%0d j=%0d expected i=5 j=6", wr_i, wr_j); end
    checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", wr_data); end
    checks++; if (req_ack !== 9'b000010000) begin errors++; $display("FAIL single_ack: got %b expected 000010000", req_ack); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", wr_count); end
    req_stb[4] = 1'b0;
    tick();
    checks++; if ({req_ack, wr_en} !== 10'd0) begin errors++; $display("FAIL single_one_cycle: got %b expected 0", {req_ack, wr_en}); end
  endtask

  task automatic test_out_of_range;
    set_req(2, 2'd0, 2'd3, 32'h1234_5678);
    tick();
    checks++; if (req_ack !== 9'b000000100) begin errors++; $display("FAIL oor_ack: got %b expected 000000100", req_ack); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL oor_wr_en: got %b expected 0", wr_en); end
    checks++; if ({wr_count, drop_count} !== {16'd1, 16'd1}) begin errors++; $display("FAIL oor_counts: got wr=%0d drop=%0d expected wr=1 drop=1", wr_count, drop_count); end
    req_stb[2] = 1'b0;
  endtask

  task automatic test_fairness;
    int exp_seq[6] = '{3, 8, 0, 3, 8, 0};
    set_req(0, 2'd0, 2'd0, 32'h0000_0A00);
    set_req(3, 2'd0, 2'd0, 32'h0000_0A03);
    set_req(8, 2'd0, 2'd0, 32'h0000_0A08);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({req_ack, wr_en} !== {9'd1 << exp_seq[i], 1'b1}) begin errors++; $display("FAIL fair_grant%0d: got ack=%b wr_en=%b expected tile %0d", i, req_ack, wr_en, exp_seq[i]); end
    end
    req_stb = '0;
    tick();
    checks++; if ({req_ack, wr_count} !== {9'd0, 16'd7}) begin errors++; $display("FAIL fair_end: got ack=%b count=%0d expected ack=0 count=7", req_ack, wr_count); end
  endtask

  task automatic test_drain;
    set_req(1, 2'd0, 2'd0, 32'h0000_0B01);
    set_req(7, 2'd0, 2'd0, 32'h0000_0B07);
    req_done = '1;
    tick();
    req_done = '0;
    checks++; if ({req_ack, busy, done} !== {9'b000000010, 2'b10}) begin errors++; $display("FAIL drain_ack1: got ack=%b busy=%b done=%b expected ack=000000010 busy=1 done=0", req_ack, busy, done); end
    req_stb[1] = 1'b0;
    tick();
    checks++; if ({req_ack, busy, done} !== {9'b010000000, 2'b10}) begin errors++; $display("FAIL drain_ack2: got ack=%b busy=%b done=%b expected ack=010000000 busy=1 done=0", req_ack, busy, done); end
    checks++; if ({wr_i, wr_j} !== {4'd8, 4'd4}) begin errors++; $display("FAIL drain_addr: got i=%0d j=%0d expected i=8 j=4", wr_i, wr_j); end
    req_stb[7] = 1'b0;
    tick();
    checks++; if ({req_ack, busy, done} !== {9'd0, 2'b01}) begin errors++; $display("FAIL drain_done: got ack=%b busy=%b done=%b expected ack=0 busy=0 done=1", req_ack, busy, done); end
    checks++; if (wr_count !== 16'd9) begin errors++; $display("FAIL drain_count: got %0d expected 9", wr_count); end
  endtask

  task automatic test_start_in_done;
    set_req(2, 2'd0, 2'd0, 32'hA5A5_0002);
    set_req(8, 2'd0, 2'd0, 32'hA5A5_0008);
    repeat (2) tick();
    checks++; if ({req_ack, done} !== {9'd0, 1'b1}) begin errors++; $display("FAIL done_hold: got ack=%b done=%b expected ack=0 done=1", req_ack, done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({busy, done, req_ack} !== {2'b10, 9'd0}) begin errors++; $display("FAIL restart_flags: got busy=%b done=%b ack=%b expected busy=1 done=0 ack=0", busy, done, req_ack); end
    checks++; if ({wr_count, drop_count} !== 32'd0) begin errors++; $display("FAIL restart_counts: got wr=%0d drop=%0d expected 0", wr_count, drop_count); end
    tick();
    checks++; if (req_ack !== 9'b000000100) begin errors++; $display("FAIL restart_ptr: got %b expected 000000100", req_ack); end
    checks++; if ({wr_i, wr_j, wr_data} !== {4'd0, 4'd8, 32'hA5A5_0002}) begin errors++; $display("FAIL restart_write: got i=%0d j=%0d data=%h expected i=0 j=8 data=a5a50002", wr_i, wr_j, wr_data); end
    req_stb[2] = 1'b0;
    tick();
    checks++; if ({req_ack, wr_i, wr_j, wr_count} !== {9'b100000000, 4'd8, 4'd8, 16'd2}) begin errors++; $display("FAIL restart_second: got ack=%b i=%0d j=%0d count=%0d expected ack=100000000 i=8 j=8 count=2", req_ack, wr_i, wr_j, wr_count); end
    req_stb[8] = 1'b0;
    tick();
    checks++; if (req_ack !== 9'd0) begin errors++; $display("FAIL restart_quiet: got %b expected 0", req_ack); end
  endtask

  task automatic test_reset_mid_run;
    set_req(0, 2'd0, 2'd0, 32'h0000_0C00);
    set_req(1, 2'd0, 2'd0, 32'h0000_0C01);
    set_req(3, 2'd0, 2'd0, 32'h0000_0C03);
    set_req(4, 2'd0, 2'd0, 32'h0000_0C04);
    set_req(6, 2'd0, 2'd0, 32'h0000_0C06);
    tick();
    checks++; if ({req_ack, wr_en, wr_count} !== {9'b000000001, 1'b1, 16'd3}) begin errors++; $display("FAIL mid_pre: got ack=%b wr_en=%b count=%0d expected ack=000000001 wr_en=1 count=3", req_ack, wr_en, wr_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({req_ack, wr_en, busy, done} !== 12'd0) begin errors++; $display("FAIL mid_rst_flags: got %b expected 0", {req_ack, wr_en, busy, done}); end
    checks++; if ({wr_i, wr_j, wr_data, wr_count, drop_count} !== 72'd0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", {wr_i, wr_j, wr_data, wr_count, drop_count}); end
    repeat (2) tick();
    checks++; if ({req_ack, wr_en} !== 10'd0) begin errors++; $display("FAIL mid_rst_hold: got %b expected 0", {req_ack, wr_en}); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({req_ack, wr_en, busy} !== 11'd0) begin errors++; $display("FAIL post_rst_idle%0d: got %b expected 0", i, {req_ack, wr_en, busy}); end
    end
    req_stb = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_out_of_range();
    test_fairness();
    test_drain();
    test_start_in_done();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
